// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: zeroing sweep after reset, then
// round-robin arbitration between execute and load writeback.
module regfile_write_arbiter #(
    parameter int WORD           = 64,
    parameter int ADDR_W         = 5,
    parameter int ZERO_REG       = 31,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [WORD-1:0]   ex_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [WORD-1:0]   mem_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_register,
    output logic [WORD-1:0]   write_data,
    output logic              init_done,
    output logic              xzr_drop
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              last_mem;
    logic              grant_ex;
    logic              grant_mem;
    logic [ADDR_W-1:0] sel_rd;
    logic [WORD-1:0]   sel_data;

    // State register; reset picks sweep or straight-to-run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? INIT : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave the sweep once the counter has passed the last real register
    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == ZR) begin
            state_nxt = RUN;
        end
    end

    // Round-robin grant and the selected write payload
    always_comb begin
        grant_ex  = 1'b0;
        grant_mem = 1'b0;
        if (state == RUN) begin
            grant_ex  = ex_valid && (!mem_valid || last_mem);
            grant_mem = mem_valid && !grant_ex;
        end
        ex_ready  = grant_ex;
        mem_ready = grant_mem;
        sel_rd    = grant_mem ? mem_rd : ex_rd;
        sel_data  = grant_mem ? mem_data : ex_data;
    end

    // Registered write port, sweep counter and grant history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            init_done      <= 1'b0;
            xzr_drop       <= 1'b0;
            cnt            <= '0;
            last_mem       <= 1'b1;
        end else if (state == INIT) begin
            xzr_drop <= 1'b0;
            if (cnt != ZR) begin
                reg_write      <= 1'b1;
                write_register <= cnt;
                write_data     <= '0;
                cnt            <= cnt + ADDR_W'(1);
            end else begin
                reg_write <= 1'b0;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
            if (grant_ex || grant_mem) begin
                last_mem <= grant_mem;
                if (sel_rd == ZR) begin
                    reg_write <= 1'b0;
                    xzr_drop  <= 1'b1;
                end else begin
                    reg_write      <= 1'b1;
                    xzr_drop       <= 1'b0;
                    write_register <= sel_rd;
                    write_data     <= sel_data;
                end
            end else begin
                reg_write <= 1'b0;
                xzr_drop  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: sweep, round-robin, XZR drop,
// mid-sweep reset, and the no-clear variant.
module tb_regfile_write_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, mem_valid, mem_ready;
    logic [4:0]  ex_rd, mem_rd, write_register;
    logic [63:0] ex_data, mem_data, write_data;
    logic        reg_write, init_done, xzr_drop;

    logic        rst_n0;
    logic        ex_valid0, ex_ready0, mem_valid0, mem_ready0;
    logic [4:0]  ex_rd0, mem_rd0, write_register0;
    logic [63:0] ex_data0, mem_data0, write_data0;
    logic        reg_write0, init_done0, xzr_drop0;

    wr_t exp_q[$];
    wr_t w;
    int  passed = 0;
    int  total  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write(reg_write), .write_register(write_register),
        .write_data(write_data), .init_done(init_done),
        .xzr_drop(xzr_drop)
    );

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n0),
        .ex_valid(ex_valid0), .ex_ready(ex_ready0),
        .ex_rd(ex_rd0), .ex_data(ex_data0),
        .mem_valid(mem_valid0), .mem_ready(mem_ready0),
        .mem_rd(mem_rd0), .mem_data(mem_data0),
        .reg_write(reg_write0), .write_register(write_register0),
        .write_data(write_data0), .init_done(init_done0),
        .xzr_drop(xzr_drop0)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 64'h77;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 64'h88;
        #1;
        total++;
        if ({reg_write, write_register, write_data, init_done, xzr_drop} !== '0)
            $display("FAIL reset_outs: got %b/%h/%h/%b/%b exp all 0",
                     reg_write, write_register, write_data, init_done, xzr_drop);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            total++;
            if (i <= 31) begin
                if (reg_write !== 1'b1 || write_register !== 5'(i - 1) ||
                    write_data !== 64'd0 || init_done !== 1'b0 ||
                    ex_ready !== 1'b0 || mem_ready !== 1'b0)
                    $display("FAIL sweep_edge%0d: got we=%b wr=%0d wd=%h id=%b rdy=%b%b exp we=1 wr=%0d wd=0 id=0 rdy=00",
                             i, reg_write, write_register, write_data, init_done,
                             ex_ready, mem_ready, i - 1);
                else passed++;
            end else begin
                if (reg_write !== 1'b0 || init_done !== 1'b1)
                    $display("FAIL sweep_done: got we=%b id=%b exp we=0 id=1",
                             reg_write, init_done);
                else passed++;
            end
        end
        ex_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_tie();
        int  ei = 0;
        int  mi = 0;
        int  wi = 0;
        bit  mlast_mem = 1'b1;
        bit  gex, gmem;
        int  ord[8] = '{1, 9, 2, 10, 3, 11, 4, 12};
        for (int k = 0; k < 9; k++) begin
            total++;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                if (reg_write !== 1'b1 || write_register !== w.rd ||
                    write_data !== w.d || write_register !== 5'(ord[wi]))
                    $display("FAIL tie_write%0d: got we=%b wr=%0d wd=%h exp we=1 wr=%0d wd=%h",
                             wi, reg_write, write_register, write_data, ord[wi], w.d);
                else passed++;
                wi++;
            end else begin
                if (reg_write !== 1'b0)
                    $display("FAIL tie_idle: got we=%b exp 0", reg_write);
                else passed++;
            end
            ex_valid = (ei < 4); ex_rd = 5'(1 + ei); ex_data = 64'(32'hE0 + ei);
            mem_valid = (mi < 4); mem_rd = 5'(9 + mi); mem_data = 64'(32'hA0 + mi);
            #1;
            gex  = ex_valid && (!mem_valid || mlast_mem);
            gmem = mem_valid && !gex;
            total++;
            if (ex_ready !== gex || mem_ready !== gmem)
                $display("FAIL tie_grant%0d: got rdy=%b%b exp rdy=%b%b",
                         k, ex_ready, mem_ready, gex, gmem);
            else passed++;
            if (gex) begin
                exp_q.push_back('{ex_rd, ex_data}); ei++; mlast_mem = 1'b0;
            end
            if (gmem) begin
                exp_q.push_back('{mem_rd, mem_data}); mi++; mlast_mem = 1'b1;
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        mem_valid = 1'b0;
        total++;
        if (wi !== 8 || exp_q.size() !== 0)
            $display("FAIL tie_count: got %0d writes exp 8", wi);
        else passed++;
    endtask

    task automatic test_single();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 64'h1234;
        #1;
        total++;
        if (ex_ready !== 1'b1 || mem_ready !== 1'b0)
            $display("FAIL single_ready: got %b%b exp 10", ex_ready, mem_ready);
        else passed++;
        exp_q.push_back('{5'd5, 64'h1234});
        @(posedge clk); #1;
        ex_valid = 1'b0;
        w = exp_q.pop_front();
        total++;
        if (reg_write !== 1'b1 || write_register !== w.rd || write_data !== w.d)
            $display("FAIL single_write: got we=%b wr=%0d wd=%h exp we=1 wr=%0d wd=%h",
                     reg_write, write_register, write_data, w.rd, w.d);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (reg_write !== 1'b0 || write_register !== 5'd5 || write_data !== 64'h1234)
            $display("FAIL single_idle: got we=%b wr=%0d wd=%h exp we=0 wr=5 wd=1234",
                     reg_write, write_register, write_data);
        else passed++;
    endtask

    task automatic test_xzr();
        mem_valid = 1'b1; mem_rd = 5'd31; mem_data = 64'hFF;
        #1;
        total++;
        if (mem_ready !== 1'b1 || ex_ready !== 1'b0)
            $display("FAIL xzr_ready: got %b%b exp 01", ex_ready, mem_ready);
        else passed++;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        total++;
        if (xzr_drop !== 1'b1 || reg_write !== 1'b0 ||
            write_register !== 5'd5 || write_data !== 64'h1234)
            $display("FAIL xzr_drop: got xd=%b we=%b wr=%0d wd=%h exp xd=1 we=0 wr=5 wd=1234",
                     xzr_drop, reg_write, write_register, write_data);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (xzr_drop !== 1'b0)
            $display("FAIL xzr_pulse: got %b exp 0", xzr_drop);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (write_register !== 5'd9 || reg_write !== 1'b1)
            $display("FAIL mid_edge10: got we=%b wr=%0d exp we=1 wr=9",
                     reg_write, write_register);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (reg_write !== 1'b0 || write_register !== 5'd0 || init_done !== 1'b0)
            $display("FAIL mid_clear: got we=%b wr=%0d id=%b exp 0/0/0",
                     reg_write, write_register, init_done);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (i == 1 || i == 31) begin
                total++;
                if (reg_write !== 1'b1 || write_register !== 5'(i - 1) || init_done !== 1'b0)
                    $display("FAIL mid_sweep%0d: got we=%b wr=%0d id=%b exp we=1 wr=%0d id=0",
                             i, reg_write, write_register, init_done, i - 1);
                else passed++;
            end else if (i == 32) begin
                total++;
                if (init_done !== 1'b1 || reg_write !== 1'b0)
                    $display("FAIL mid_done: got id=%b we=%b exp id=1 we=0",
                             init_done, reg_write);
                else passed++;
            end
        end
    endtask

    task automatic test_no_clear();
        ex_valid0 = 1'b1; ex_rd0 = 5'd3; ex_data0 = 64'h33;
        @(negedge clk) rst_n0 = 1'b1;
        #1;
        total++;
        if (ex_ready0 !== 1'b1 || init_done0 !== 1'b0)
            $display("FAIL nc_ready: got rdy=%b id=%b exp rdy=1 id=0",
                     ex_ready0, init_done0);
        else passed++;
        exp_q.push_back('{5'd3, 64'h33});
        @(posedge clk); #1;
        ex_valid0 = 1'b0;
        w = exp_q.pop_front();
        total++;
        if (init_done0 !== 1'b1 || reg_write0 !== 1'b1 ||
            write_register0 !== w.rd || write_data0 !== w.d)
            $display("FAIL nc_write: got id=%b we=%b wr=%0d wd=%h exp id=1 we=1 wr=%0d wd=%h",
                     init_done0, reg_write0, write_register0, write_data0, w.rd, w.d);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (reg_write0 !== 1'b0)
            $display("FAIL nc_idle: got we=%b exp 0", reg_write0);
        else passed++;
    endtask

    initial begin
        rst_n0 = 1'b0;
        ex_valid0 = 1'b0; ex_rd0 = '0; ex_data0 = '0;
        mem_valid0 = 1'b0; mem_rd0 = '0; mem_data0 = '0;
        test_reset();
        test_tie();
        test_single();
        test_xzr();
        test_reset_mid();
        test_no_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
